melody_sequencer: RTL and testbench

//  Upstream stage of the buzzer driver. Steps through a note ROM and drives tone/en.

---
 rtl/melody_pkg.sv | 56 +++++
 rtl/melody_rom.sv | 57 +++++
 rtl/melody_sequencer.sv | 140 ++++++++++++++
 tb/tb_melody_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: tone codes, duration codes,
// ROM word layout and FSM state encoding.
package melody_pkg;

  localparam int unsigned TONE_W = 5;
  localparam int unsigned DUR_W  = 2;
  localparam int unsigned WORD_W = 8;

  localparam int unsigned END_BIT  = 7;
  localparam int unsigned DUR_LSB  = 5;
  localparam int unsigned TONE_LSB = 0;

  localparam logic [TONE_W-1:0] REST = 5'd0;
  localparam logic [TONE_W-1:0] L1 = 5'd1,  L2 = 5'd2,  L3 = 5'd3,  L4 = 5'd4;
  localparam logic [TONE_W-1:0] L5 = 5'd5,  L6 = 5'd6,  L7 = 5'd7;
  localparam logic [TONE_W-1:0] M1 = 5'd8,  M2 = 5'd9,  M3 = 5'd10, M4 = 5'd11;
  localparam logic [TONE_W-1:0] M5 = 5'd12, M6 = 5'd13, M7 = 5'd14;
  localparam logic [TONE_W-1:0] H1 = 5'd15, H2 = 5'd16, H3 = 5'd17, H4 = 5'd18;
  localparam logic [TONE_W-1:0] H5 = 5'd19, H6 = 5'd20, H7 = 5'd21;

  localparam logic [DUR_W-1:0] DUR_1 = 2'd0;
  localparam logic [DUR_W-1:0] DUR_2 = 2'd1;
  localparam logic [DUR_W-1:0] DUR_4 = 2'd2;
  localparam logic [DUR_W-1:0] DUR_8 = 2'd3;

  typedef struct packed {
    logic              last;
    logic [DUR_W-1:0]  dur;
    logic [TONE_W-1:0] tone;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Pack a note into the 8-bit ROM word layout.
  function automatic note_t mk_note(input logic [TONE_W-1:0] tone,
                                    input logic [DUR_W-1:0]  dur,
                                    input logic              last);
    logic [WORD_W-1:0] w;
    w                      = '0;
    w[END_BIT]             = last;
    w[DUR_LSB +: DUR_W]    = dur;
    w[TONE_LSB +: TONE_W]  = tone;
    return note_t'(w);
  endfunction

  // Duration code 0..3 maps to 1/2/4/8 units.
  function automatic int unsigned dur_units(input logic [DUR_W-1:0] dur);
    return 32'd1 << dur;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Song table with registered read data (one-cycle latency).
// SONG=0 selects the production tune, SONG=1 the short three-note test tune.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned SONG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  output note_t             o_data
);

  note_t w_note;
  note_t r_data;

  always_comb begin
    w_note = mk_note(REST, DUR_1, 1'b1);
    if (SONG == 1) begin
      case (32'(i_addr))
        0:       w_note = mk_note(M1,   DUR_1, 1'b0);
        1:       w_note = mk_note(REST, DUR_2, 1'b0);
        2:       w_note = mk_note(H7,   DUR_4, 1'b1);
        default: w_note = mk_note(REST, DUR_1, 1'b1);
      endcase
    end else begin
      // Twinkle Twinkle, first phrase, with a breath rest mid-phrase.
      case (32'(i_addr))
        0:       w_note = mk_note(M1,   DUR_4, 1'b0);
        1:       w_note = mk_note(M1,   DUR_4, 1'b0);
        2:       w_note = mk_note(M5,   DUR_4, 1'b0);
        3:       w_note = mk_note(M5,   DUR_4, 1'b0);
        4:       w_note = mk_note(M6,   DUR_4, 1'b0);
        5:       w_note = mk_note(M6,   DUR_4, 1'b0);
        6:       w_note = mk_note(M5,   DUR_8, 1'b0);
        7:       w_note = mk_note(REST, DUR_2, 1'b0);
        8:       w_note = mk_note(M4,   DUR_4, 1'b0);
        9:       w_note = mk_note(M4,   DUR_4, 1'b0);
        10:      w_note = mk_note(M3,   DUR_4, 1'b0);
        11:      w_note = mk_note(M3,   DUR_4, 1'b0);
        12:      w_note = mk_note(M2,   DUR_4, 1'b0);
        13:      w_note = mk_note(M2,   DUR_4, 1'b0);
        14:      w_note = mk_note(M1,   DUR_8, 1'b1);
        default: w_note = mk_note(REST, DUR_1, 1'b1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_data <= note_t'('0);
    else        r_data <= w_note;
  end

  assign o_data = r_data;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the note ROM and drives the buzzer tone/enable, with an
// en-low articulation gap closing every note.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned UNIT_CYC = 1_500_000,
  parameter int unsigned GAP_CYC  = 120_000,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned SONG     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  output logic [TONE_W-1:0] tone_o,
  output logic              en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = $clog2(8 * UNIT_CYC);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
  logic                r_last,  w_last_nxt;
  logic [TONE_W-1:0]   r_tone,  w_tone_nxt;
  logic                r_en,    w_en_nxt;
  logic                r_busy,  w_busy_nxt;
  logic                r_done,  w_done_nxt;

  note_t               w_note;
  logic [CNT_W-1:0]    w_load_cnt;

  melody_rom #(
    .ADDR_W (ADDR_W),
    .SONG   (SONG)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (w_addr_nxt),
    .o_data (w_note)
  );

  // LOAD + PLAY + GAP together last exactly units*UNIT_CYC cycles.
  assign w_load_cnt = CNT_W'(dur_units(w_note.dur) * UNIT_CYC - GAP_CYC - 32'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_tone_nxt  = r_tone;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_LOAD;
          w_addr_nxt  = '0;
        end
      end
      ST_LOAD: begin
        w_last_nxt  = w_note.last;
        w_tone_nxt  = w_note.tone;
        w_cnt_nxt   = w_load_cnt;
        w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        w_en_nxt = (r_tone != '0);
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = CNT_W'(GAP_CYC - 32'd1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!r_last) begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = ST_LOAD;
        end else if (loop_i) begin
          w_addr_nxt  = '0;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_tone_nxt  = '0;
          w_addr_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides every state transition and output update.
    if (stop_i) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_last_nxt  = 1'b0;
      w_tone_nxt  = '0;
      w_en_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_tone  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_tone  <= w_tone_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tone_o = r_tone;
  assign en_o   = r_en;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer on the three-note test song:
// a timeline model predicts every output change, a monitor checks them.
module tb_melody_sequencer;

  localparam int UC   = 10;
  localparam int GAP  = 2;
  localparam int MAXL = 256;

  typedef struct packed {
    logic [4:0] tone;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       loop_i = 1'b0;
  logic [4:0] tone_o;
  logic       en_o, busy_o, done_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_hold = 1'b1;
  ev_t  exp_q[$];
  obs_t prev = '0;

  int s_tone[3] = '{8, 0, 21};
  int s_dur[3]  = '{0, 1, 2};
  int s_end[3]  = '{0, 0, 1};

  melody_sequencer #(
    .UNIT_CYC (UC),
    .GAP_CYC  (GAP),
    .ADDR_W   (6),
    .SONG     (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .stop_i  (stop_i),
    .loop_i  (loop_i),
    .tone_o  (tone_o),
    .en_o    (en_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output tuple must match the next expected event.
  always @(negedge clk) begin
    obs_t cur;
    ev_t  e;
    cur = '{tone: tone_o, en: en_o, busy: busy_o, done: done_o};
    if (mon_hold) begin
      prev = cur;
    end else if (cur != prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got tone=%0d en=%0d busy=%0d done=%0d",
                 cyc, cur.tone, cur.en, cur.busy, cur.done);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v != cur) begin
          n_fail++;
          $display("FAIL event got cyc=%0d tone=%0d en=%0d busy=%0d done=%0d, want cyc=%0d tone=%0d en=%0d busy=%0d done=%0d",
                   cyc, cur.tone, cur.en, cur.busy, cur.done,
                   e.cyc, e.v.tone, e.v.en, e.v.busy, e.v.done);
        end
      end
      prev = cur;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Plays the song once from IDLE; hold = start_i high cycles, stop_at = -1 for no abort.
  task automatic run_song(input int hold, input bit lp, input int stop_at);
    obs_t tr[MAXL];
    obs_t pv;
    int   len, t, a, base, p;
    ev_t  e;
    len = 0;
    for (int i = 0; i < 3; i++) len += (1 << s_dur[i]) * UC;
    len = (stop_at >= 0) ? stop_at + 3 : len + 3;
    for (int c = 0; c < MAXL; c++) tr[c] = '0;

    // Timeline: note starting at t lasts p cycles; tone from t+1, en from t+2 until GAP.
    t = 0;
    a = 0;
    while (t <= len) begin
      p = (1 << s_dur[a]) * UC;
      for (int c = t; c < t + p; c++) if (c <= len) tr[c].busy = 1'b1;
      for (int c = t + 1; c < t + p; c++) if (c <= len) tr[c].tone = 5'(s_tone[a]);
      if (s_tone[a] != 0)
        for (int c = t + 2; c <= t + p - GAP; c++) if (c <= len) tr[c].en = 1'b1;
      if (s_end[a] != 0 && !lp) begin
        if (t + p <= len) tr[t + p].done = 1'b1;
        break;
      end
      if (t + p <= len) tr[t + p].tone = 5'(s_tone[a]);
      a = (s_end[a] != 0) ? 0 : a + 1;
      t += p;
    end
    if (stop_at >= 0)
      for (int c = stop_at; c <= len; c++) tr[c] = '0;

    @(negedge clk);
    base = cyc + 1;
    pv = '0;
    for (int c = 0; c <= len; c++) begin
      if (tr[c] != pv) begin
        e.cyc = base + c;
        e.v   = tr[c];
        exp_q.push_back(e);
        pv = tr[c];
      end
    end
    loop_i = lp;
    for (int k = 0; k <= len + 2; k++) begin
      start_i = (k < hold);
      stop_i  = (k == stop_at);
      @(negedge clk);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    loop_i  = 1'b0;
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Asynchronous reset while the first note sounds.
  task automatic reset_mid_play();
    mon_hold = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_en", int'(en_o), 1);
    check("pre_reset_tone", int'(tone_o), 8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tone", int'(tone_o), 0);
    check("async_rst_en", int'(en_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_done", int'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", int'(busy_o), 0);
    mon_hold = 1'b0;
  endtask

  initial begin
    int hold, stop_at;
    bit lp;
    repeat (3) @(negedge clk);
    check("reset_tone", int'(tone_o), 0);
    check("reset_en", int'(en_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_hold = 1'b0;

    run_song(1, 1'b0, -1);
    run_song(1, 1'b1, 95);
    run_song(8, 1'b0, -1);
    run_song(1, 1'b0, 45);
    run_song(1, 1'b0, 70);
    run_song(2, 1'b0, 3);
    reset_mid_play();
    run_song(1, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      hold = int'($urandom_range(1, 9));
      lp   = 1'($urandom_range(0, 1));
      if (lp)
        stop_at = int'($urandom_range(32'(hold + 1), 150));
      else if ($urandom_range(0, 1) == 1)
        stop_at = int'($urandom_range(32'(hold + 1), 80));
      else
        stop_at = -1;
      run_song(hold, lp, stop_at);
      repeat (int'($urandom_range(0, 4))) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
